p_counter_arbiter: RTL and testbench
====================================

Name: p_counter_arbiter

Overview:
Shares one WIDTH-bit up-counter (same counting datapath as p_counter) among NREQ requesters, each needing a timed interval of a requested length. A round-robin arbiter grants the counter to one requester, runs it for that requester's interval, then signals completion. Sits between interval-timing clients and the shared counting resource.

Parameters:
WIDTH, 8, counter and interval-length width
NREQ, 4, number of requesters (2..16)
IDW, $clog2(NREQ), derived localparam, owner index width

Ports:
clk  in  1  rising-edge clock
clear_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level; must be held for the whole interval
len  in  NREQ*WIDTH  packed lengths; requester i at bits [i*WIDTH +: WIDTH]; 0 means 2**WIDTH cycles
gnt  out  NREQ  one-hot grant, high for exactly the interval
done  out  NREQ  one-hot, one-cycle completion pulse
busy  out  1  high while a grant is active (equals |gnt)
count  out  WIDTH  shared counter value, 0 when not running
owner  out  IDW  index of the current or most recent grantee

Behaviour:
- Reset (clear_n low, async, takes effect immediately): state=IDLE; gnt=0, done=0, busy=0, count=0, owner=0; internal round-robin pointer last=NREQ-1, so requester 0 has first priority.
- States: IDLE, RUN, DONE. All outputs are registered.
- Arbitration, performed in IDLE and DONE: if req!=0, the winner is the first set bit searching from last+1 upward, wrapping modulo NREQ.
- On that edge:
  - state<=RUN, gnt<=onehot(w), owner<=w, last<=w, count<=0.
  - target<=len[w]; the length is latched, and later len changes are ignored.
- If req==0 in IDLE, stay in IDLE. If req==0 in DONE, go to IDLE.
- RUN, evaluated at each edge:
  - Abort (highest priority): if req[owner]==0, then state<=IDLE, gnt<=0, count<=0, no done pulse.
  - Terminal: else if count==target-1 (mod 2**WIDTH), then state<=DONE, gnt<=0, done[owner]<=1, count<=0.
  - Otherwise count<=count+1.
- Resulting timing:
  - gnt is high for exactly L cycles, and count shows 0,1,..,L-1 during them.
  - L=0 gives 2**WIDTH cycles: count runs to 2**WIDTH-1, and the wrap is the terminal.
  - L=1 gives one cycle with count=0.
- DONE lasts one cycle:
  - done<=0 on leaving.
  - If another request is pending, its gnt rises on the edge leaving DONE.
  - This leaves exactly one gap cycle between consecutive grants.
- Request timing:
  - A req asserted during RUN by a non-owner waits; it is never pre-empted into the current interval.
  - A req dropped and re-raised by a non-owner needs no special handling.
- Granularity: the latency from req rising in IDLE to gnt is 1 clock edge.
- Fairness: with all NREQ requesters continuously requesting, the grants cycle 0,1,..,NREQ-1,0,..
- busy==|gnt at all times. done and gnt are never high in the same cycle.
- Reset asserted mid-RUN:
  - The interval is lost, with no done pulse.
  - After release, arbitration restarts with requester 0 at highest priority.
- Unused len slices of non-requesting clients are don't-care.

Test Plan:
1. Only req[0], len[0]=5, held → gnt[0] rises one edge after req; high 5 cycles with count 0,1,2,3,4; then done=4'b0001 for 1 cycle; busy tracks gnt; then IDLE.
2. req[0] and req[2] held, len=3 each → grant order 0,2,0,2; each gnt 3 cycles; one DONE gap cycle between grants; owner alternates 0,2.
3. req[1], len[1]=0, WIDTH=8 → gnt[1] high 256 cycles; count reaches 255; then count=0, done[1] pulse.
4. req[3], len[3]=10; drop req[3] while count=3 → next edge gnt=0, count=0, busy=0, no done. Then req[0] and req[3] both raised → gnt[0] first (pointer after 3).
5. len=1 on req[2] → gnt[2] for exactly one cycle at count=0, followed by a done[2] pulse.
6. clear_n pulsed low mid-RUN (count=4 of len 8) → gnt, count, busy, done zero immediately, without a clock edge. After release with req[0] and req[1] set → gnt[0] first.

Source files
------------

// File: rtl/p_counter_arbiter.sv
// Round-robin arbiter sharing one up-counter among NREQ interval-timing clients.
// The grantee's length is latched at grant time. The counter runs 0..L-1, with L=0 meaning
// 2**WIDTH cycles. A one-cycle done pulse follows unless the owner drops its request first.
module p_counter_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [IDW-1:0]        owner
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_q, last_d;

  logic             arb_found;
  logic [IDW-1:0]   arb_win;
  int unsigned      arb_idx;

  // Round-robin search: first set request strictly after last_q, wrapping modulo NREQ.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      arb_idx = (32'(last_q) + k) % NREQ;
      if (!arb_found && req[arb_idx]) begin
        arb_found = 1'b1;
        arb_win   = arb_idx[IDW-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    count_d  = count_q;
    target_d = target_q;
    owner_d  = owner_q;
    last_d   = last_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (arb_found) begin
          state_d  = StRun;
          gnt_d    = NREQ'(1) << arb_win;
          owner_d  = arb_win;
          last_d   = arb_win;
          count_d  = '0;
          target_d = len[arb_win*WIDTH +: WIDTH];
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      StRun: begin
        if (!req[owner_q]) begin
          // Owner abandoned the interval: no completion pulse.
          state_d = StIdle;
          gnt_d   = '0;
          count_d = '0;
        end else if (count_q == target_q - WIDTH'(1)) begin
          // Wrapping subtraction makes a zero target run the full 2**WIDTH cycles.
          state_d = StDone;
          gnt_d   = '0;
          done_d  = NREQ'(1) << owner_q;
          count_d = '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // State register; reset points the round-robin pointer at the last requester.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      done_q   <= '0;
      count_q  <= '0;
      target_q <= '0;
      owner_q  <= '0;
      last_q   <= IDW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      count_q  <= count_d;
      target_q <= target_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = |gnt_q;
  assign count = count_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_p_counter_arbiter.sv
// Directed bench for p_counter_arbiter (WIDTH=8, NREQ=4).
module tb_p_counter_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  clear_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [1:0]            owner;

  int total = 0;
  int bad   = 0;

  p_counter_arbiter #(
    .WIDTH(WIDTH),
    .NREQ (NREQ)
  ) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .req    (req),
    .len    (len),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .count  (count),
    .owner  (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ*WIDTH-1:0] mk_len(input logic [7:0] l0, input logic [7:0] l1,
                                                   input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    clear_n = 1'b1;
    req     = '0;
    len     = '0;
    #1 clear_n = 1'b0;
    #2;
    // Reset state, before any clock edge.
    chk_idle("rst");
    chk("rst_owner", 32'(owner), 32'd0);
    tick();
    clear_n = 1'b1;
    tick();
    chk_idle("idle0");

    // 1: single requester, len 5.
    len = mk_len(8'd5, 8'd0, 8'd0, 8'd0);
    req = 4'b0001;
    chk("t1_pre_gnt", 32'(gnt), 32'd0);
    tick();
    chk("t1_gnt", 32'(gnt), 32'b0001);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_owner", 32'(owner), 32'd0);
    chk("t1_cnt0", 32'(count), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t1_cnt", 32'(count), 32'(i));
      chk("t1_gnt_hold", 32'(gnt), 32'b0001);
    end
    tick();
    chk("t1_done", 32'(done), 32'b0001);
    chk("t1_gnt_off", 32'(gnt), 32'd0);
    chk("t1_busy_off", 32'(busy), 32'd0);
    chk("t1_cnt_off", 32'(count), 32'd0);
    req = 4'b0000;
    tick();
    chk_idle("t1_end");

    // Fresh pointer so requester 0 leads test 2.
    clear_n = 1'b0;
    #1;
    chk_idle("rst2");
    clear_n = 1'b1;

    // 2: requesters 0 and 2, len 3 each, alternate 0,2,0,2 with one gap cycle.
    len = mk_len(8'd3, 8'd0, 8'd3, 8'd0);
    req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      int w;
      w = (g % 2 == 0) ? 0 : 2;
      tick();
      chk("t2_gnt", 32'(gnt), 32'd1 << w);
      chk("t2_owner", 32'(owner), 32'(w));
      chk("t2_done_low", 32'(done), 32'd0);
      chk("t2_cnt0", 32'(count), 32'd0);
      for (int c = 1; c <= 2; c++) begin
        tick();
        chk("t2_cnt", 32'(count), 32'(c));
        chk("t2_gnt_hold", 32'(gnt), 32'd1 << w);
      end
      tick();
      chk("t2_gap_gnt", 32'(gnt), 32'd0);
      chk("t2_done", 32'(done), 32'd1 << w);
    end
    req = 4'b0000;
    tick();
    chk_idle("t2_end");

    // 3: len 0 on requester 1 runs 256 cycles.
    len = mk_len(8'd0, 8'd0, 8'd0, 8'd0);
    req = 4'b0010;
    tick();
    chk("t3_gnt", 32'(gnt), 32'b0010);
    chk("t3_owner", 32'(owner), 32'd1);
    chk("t3_cnt0", 32'(count), 32'd0);
    for (int c = 1; c <= 255; c++) begin
      tick();
      chk("t3_cnt", 32'(count), 32'(c));
    end
    chk("t3_gnt_last", 32'(gnt), 32'b0010);
    tick();
    chk("t3_done", 32'(done), 32'b0010);
    chk("t3_gnt_off", 32'(gnt), 32'd0);
    chk("t3_cnt_off", 32'(count), 32'd0);
    req = 4'b0000;
    tick();
    chk_idle("t3_end");

    // 4: abort requester 3 at count 3, then 0 wins over 3.
    len = mk_len(8'd0, 8'd0, 8'd0, 8'd10);
    req = 4'b1000;
    tick();
    chk("t4_gnt", 32'(gnt), 32'b1000);
    chk("t4_owner", 32'(owner), 32'd3);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("t4_cnt", 32'(count), 32'(c));
    end
    req = 4'b0000;
    tick();
    chk_idle("t4_abort");
    len = mk_len(8'd2, 8'd0, 8'd0, 8'd2);
    req = 4'b1001;
    tick();
    chk("t4_rr_gnt", 32'(gnt), 32'b0001);
    chk("t4_rr_owner", 32'(owner), 32'd0);
    tick();
    chk("t4_rr_cnt1", 32'(count), 32'd1);
    tick();
    chk("t4_rr_done", 32'(done), 32'b0001);
    tick();
    chk("t4_rr_gnt3", 32'(gnt), 32'b1000);
    chk("t4_rr_owner3", 32'(owner), 32'd3);
    req = 4'b0000;
    tick();
    chk_idle("t4_end");

    // 5: len 1 on requester 2.
    len = mk_len(8'd0, 8'd0, 8'd1, 8'd0);
    req = 4'b0100;
    tick();
    chk("t5_gnt", 32'(gnt), 32'b0100);
    chk("t5_cnt", 32'(count), 32'd0);
    tick();
    chk("t5_gnt_off", 32'(gnt), 32'd0);
    chk("t5_done", 32'(done), 32'b0100);
    req = 4'b0000;
    tick();
    chk_idle("t5_end");

    // 6: asynchronous reset mid-run, then requester 0 regains first priority.
    len = mk_len(8'd8, 8'd0, 8'd0, 8'd0);
    req = 4'b0001;
    tick();
    chk("t6_gnt", 32'(gnt), 32'b0001);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("t6_cnt", 32'(count), 32'(c));
    end
    #2 clear_n = 1'b0;
    #1;
    chk_idle("t6_async");
    len = mk_len(8'd2, 8'd2, 8'd0, 8'd0);
    req = 4'b0011;
    tick();
    chk_idle("t6_held");
    clear_n = 1'b1;
    tick();
    chk("t6_gnt0", 32'(gnt), 32'b0001);
    chk("t6_owner0", 32'(owner), 32'd0);
    chk("t6_done_low", 32'(done), 32'd0);
    req = 4'b0000;
    tick();
    chk_idle("t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
